// File: rtl/riscv_pkg.sv
// Shared CSR constants, trap-cause helpers and the interrupt sequencer state type.
// Consumers: irq_controller (optional IRQ_CTRL_ROUND_ROBIN_EN) and irq_arbiter.
package riscv_pkg;

  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam int          MCAUSE_IRQ_BASE = 16;
  localparam logic [31:0] MCAUSE_INT_FLAG = 32'h8000_0000;

  // Wide enough for the largest supported line count (16).
  localparam int IRQ_IDX_W = 4;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_TAKE,
    IRQ_SERVICE,
    IRQ_ACK
  } irq_state_e;

  function automatic logic [31:0] irq_mcause(input logic [IRQ_IDX_W-1:0] idx);
    return MCAUSE_INT_FLAG | (32'(MCAUSE_IRQ_BASE) + 32'(idx));
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Interrupt-side bundle between the controller (master) and the core/CSR/peripheral side (slave).
interface irq_controller_if #(
  parameter int N_IRQ = 16
);

  logic [N_IRQ-1:0] irq_req_i;
  logic [31:0]      mie_i;
  logic             stall_i;
  logic             mret_i;
  logic             int_o;
  logic [31:0]      mcause_o;
  logic [N_IRQ-1:0] irq_ret_o;
  logic             busy_o;

  modport master (
    input  irq_req_i, mie_i, stall_i, mret_i,
    output int_o, mcause_o, irq_ret_o, busy_o
  );

  modport slave (
    output irq_req_i, mie_i, stall_i, mret_i,
    input  int_o, mcause_o, irq_ret_o, busy_o
  );

endinterface

// File: rtl/irq_arbiter.sv
// Combinational winner select over the pending vector.
// IRQ_CTRL_ROUND_ROBIN_EN selects a rotating search from rr_ptr_i; otherwise lowest index wins.
module irq_arbiter
  import riscv_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic [N_IRQ-1:0]     pending_i,
  input  logic [IRQ_IDX_W-1:0] rr_ptr_i,
  output logic                 valid_o,
  output logic [IRQ_IDX_W-1:0] idx_o
);

  assign valid_o = |pending_i;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [IRQ_IDX_W-1:0] cand [N_IRQ];
  logic [N_IRQ-1:0]     hit;

  // Slot gi examines line (rr_ptr + gi) mod N_IRQ; the pointer is always < N_IRQ.
  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_cand
    logic [IRQ_IDX_W:0] sum;
    assign sum      = {1'b0, rr_ptr_i} + (IRQ_IDX_W+1)'(gi);
    assign cand[gi] = (sum >= (IRQ_IDX_W+1)'(N_IRQ))
                    ? IRQ_IDX_W'(sum - (IRQ_IDX_W+1)'(N_IRQ))
                    : IRQ_IDX_W'(sum);
    assign hit[gi]  = pending_i[cand[gi]];
  end

  always_comb begin
    idx_o = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (hit[i]) idx_o = cand[i];
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr_i;

  always_comb begin
    idx_o = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_i[i]) idx_o = IRQ_IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt sequencer: arbitrate, strobe the trap take, hold until mret, acknowledge.
// Define IRQ_CTRL_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module irq_controller
  import riscv_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  irq_controller_if.master  bus
);

  logic [N_IRQ-1:0]     pending;
  logic                 arb_valid;
  logic [IRQ_IDX_W-1:0] arb_idx;
  logic [IRQ_IDX_W-1:0] arb_ptr;

  irq_state_e           state_q, state_d;
  logic [IRQ_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]          mcause_q, mcause_d;
  logic                 int_q, int_d;
  logic                 busy_q, busy_d;
  logic [N_IRQ-1:0]     irq_ret_q, irq_ret_d;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [IRQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign arb_ptr = rr_ptr_q;
`else
  assign arb_ptr = '0;
`endif

  // Only bits 16+k of mie gate line k; the rest of the CSR is irrelevant here.
  logic unused_mie;
  assign unused_mie = ^bus.mie_i;
  assign pending    = bus.irq_req_i & bus.mie_i[16 +: N_IRQ];

  irq_arbiter #(.N_IRQ(N_IRQ)) u_arbiter (
    .pending_i (pending),
    .rr_ptr_i  (arb_ptr),
    .valid_o   (arb_valid),
    .idx_o     (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mcause_d = mcause_q;
    case (state_q)
      IRQ_IDLE: begin
        if (!bus.stall_i && arb_valid) begin
          state_d  = IRQ_TAKE;
          idx_d    = arb_idx;
          mcause_d = irq_mcause(arb_idx);
        end
      end
      IRQ_TAKE:    if (!bus.stall_i) state_d = IRQ_SERVICE;
      IRQ_SERVICE: if (bus.mret_i)   state_d = IRQ_ACK;
      IRQ_ACK:     state_d = IRQ_IDLE;
      default:     state_d = IRQ_IDLE;
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    int_d     = (state_d == IRQ_TAKE);
    busy_d    = (state_d != IRQ_IDLE);
    irq_ret_d = (state_d == IRQ_ACK) ? (N_IRQ'(1) << idx_d) : '0;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
    if (state_q == IRQ_ACK) begin
      rr_ptr_d = (idx_q == IRQ_IDX_W'(N_IRQ - 1)) ? '0 : idx_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IRQ_IDLE;
      idx_q     <= '0;
      mcause_q  <= '0;
      int_q     <= 1'b0;
      busy_q    <= 1'b0;
      irq_ret_q <= '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mcause_q  <= mcause_d;
      int_q     <= int_d;
      busy_q    <= busy_d;
      irq_ret_q <= irq_ret_d;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign bus.int_o     = int_q;
  assign bus.busy_o    = busy_q;
  assign bus.mcause_o  = mcause_q;
  assign bus.irq_ret_o = irq_ret_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed scenarios plus randomized traffic checked cycle by cycle against a
// transaction-level interrupt model; follows IRQ_CTRL_ROUND_ROBIN_EN when defined.
module tb_irq_controller;

  localparam int N = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  irq_controller_if #(.N_IRQ(N)) ifc ();

  irq_controller #(.N_IRQ(N)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifc)
  );

  logic [N-1:0] req;
  logic [31:0]  mie;
  logic         stall;
  logic         mret;

  assign ifc.irq_req_i = req;
  assign ifc.mie_i     = mie;
  assign ifc.stall_i   = stall;
  assign ifc.mret_i    = mret;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Model: which phase of the trap sequence we are in and which line is being serviced.
  localparam int PH_IDLE = 0, PH_TAKE = 1, PH_SVC = 2, PH_ACK = 3;
  int          m_phase = PH_IDLE;
  int          m_idx   = 0;
  int          m_rr    = 0;
  logic [31:0] m_cause = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] pend);
    int k;
    for (int i = 0; i < N; i++) begin
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      k = (m_rr + i) % N;
`else
      k = i;
`endif
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] pend;
    pend = req & mie[16 +: N];
    if (!rst_i) begin
      m_phase = PH_IDLE; m_idx = 0; m_rr = 0; m_cause = '0;
      return;
    end
    case (m_phase)
      PH_IDLE: if (!stall && pend != 0) begin
        m_idx   = pick(pend);
        m_cause = 32'h8000_0000 + 32'(16 + m_idx);
        m_phase = PH_TAKE;
      end
      PH_TAKE: if (!stall) m_phase = PH_SVC;
      PH_SVC:  if (mret)   m_phase = PH_ACK;
      default: begin
        m_rr    = (m_idx + 1) % N;
        m_phase = PH_IDLE;
      end
    endcase
  endtask

  // One clock: model consumes the inputs sampled at the coming edge, then outputs are compared.
  task automatic cycle();
    logic [N-1:0] exp_ack;
    model_step();
    @(posedge clk_i);
    #1;
    exp_ack = (m_phase == PH_ACK) ? (N'(1) << m_idx) : '0;
    check("int_o",     32'(ifc.int_o),     32'(m_phase == PH_TAKE));
    check("busy_o",    32'(ifc.busy_o),    32'(m_phase != PH_IDLE));
    check("mcause_o",  ifc.mcause_o,       m_cause);
    check("irq_ret_o", 32'(ifc.irq_ret_o), 32'(exp_ack));
    if (exp_ack != 0) begin
      txn++;
      $display("txn %0d: line %0d acknowledged, mcause %h", txn, m_idx, m_cause);
      req = req & ~exp_ack;
    end
  endtask

  task automatic run_until_int(input int max_cycles);
    int n;
    n = 0;
    while (ifc.int_o !== 1'b1 && n < max_cycles) begin
      cycle();
      n++;
    end
    check("int_timeout", 32'(ifc.int_o), 32'd1);
  endtask

  task automatic finish_service();
    cycle();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    cycle();
  endtask

  initial begin
    int cnt;
    logic [31:0] held_cause;
    logic [31:0] exp_rr;

    req = '0; mie = '0; stall = 1'b0; mret = 1'b0; rst_i = 1'b0;
    cycle();
    cycle();
    check("rst_int",    32'(ifc.int_o),     32'd0);
    check("rst_busy",   32'(ifc.busy_o),    32'd0);
    check("rst_mcause", ifc.mcause_o,       32'd0);
    check("rst_ret",    32'(ifc.irq_ret_o), 32'd0);
    rst_i = 1'b1;
    cycle();

    // Fixed priority between lines 3 and 5
    mie = 32'h0028_0000; req = 16'h0028;
    cycle();
    check("fp_int",    32'(ifc.int_o), 32'd1);
    check("fp_mcause", ifc.mcause_o,   32'h8000_0013);
    cycle();
    cycle();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    check("fp_ack", 32'(ifc.irq_ret_o), 32'h0000_0008);
    req = '0; mie = '0;
    cycle();
    cycle();
    check("fp_ack_one_cycle", 32'(ifc.irq_ret_o), 32'd0);

    // Masking
    req = 16'h0001; mie = '0; cnt = 0;
    repeat (20) begin
      cycle();
      cnt += int'(ifc.int_o);
    end
    check("mask_no_int", 32'(cnt), 32'd0);
    mie = 32'h0001_0000;
    cycle();
    check("mask_int",    32'(ifc.int_o), 32'd1);
    check("mask_mcause", ifc.mcause_o,   32'h8000_0010);
    finish_service();

    // Stall in IDLE, then in TAKE
    stall = 1'b1; req = 16'h0004; mie = 32'h0004_0000; cnt = 0;
    repeat (5) begin
      cycle();
      cnt += int'(ifc.busy_o);
    end
    check("stall_idle_busy", 32'(cnt), 32'd0);
    stall = 1'b0;
    cycle();
    held_cause = ifc.mcause_o;
    cnt = int'(ifc.int_o);
    stall = 1'b1;
    repeat (3) begin
      cycle();
      cnt += int'(ifc.int_o);
      check("stall_mcause_held", ifc.mcause_o, 32'h8000_0012);
    end
    stall = 1'b0;
    cycle();
    check("stall_int_cycles", 32'(cnt), 32'd4);
    check("stall_take_mcause", held_cause, 32'h8000_0012);

    // No nesting while line 2 is in service
    req = req | 16'h0001; mie = mie | 32'h0001_0000; cnt = 0;
    repeat (5) begin
      cycle();
      cnt += int'(ifc.int_o);
    end
    check("nest_no_int", 32'(cnt), 32'd0);
    mret = 1'b1;
    cycle();
    mret = 1'b0;
    check("nest_ack", 32'(ifc.irq_ret_o), 32'h0000_0004);
    run_until_int(10);
    check("nest_next_mcause", ifc.mcause_o, 32'h8000_0010);
    cycle();

    // Reset during SERVICE
    rst_i = 1'b0;
    cycle();
    check("rst_svc_busy",   32'(ifc.busy_o),    32'd0);
    check("rst_svc_mcause", ifc.mcause_o,       32'd0);
    check("rst_svc_ret",    32'(ifc.irq_ret_o), 32'd0);
    rst_i = 1'b1;
    run_until_int(10);
    check("rst_retake_mcause", ifc.mcause_o, 32'h8000_0010);
    finish_service();

    // Two lines held with re-raise after each acknowledge
    req = '0; mie = '0; rst_i = 1'b0;
    cycle();
    rst_i = 1'b1;
    mie = 32'h0003_0000; req = 16'h0003;
    for (int t = 0; t < 4; t++) begin
      run_until_int(20);
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      exp_rr = 32'h8000_0010 + 32'(t % 2);
`else
      exp_rr = 32'h8000_0010;
`endif
      check("rr_order", ifc.mcause_o, exp_rr);
      finish_service();
      req = 16'h0003;
    end

    // Randomized traffic
    req = '0; mie = 32'hFFFF_0000; rst_i = 1'b0;
    cycle();
    rst_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(0, 15) == 0) req[k] = 1'b1;
        else if (req[k] && $urandom_range(0, 63) == 0) req[k] = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) mie = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      mret  = ($urandom_range(0, 5) == 0);
      rst_i = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
